// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the MEM-stage load/store. Each access is a fixed-latency transaction.
// A global stall holds the pipeline until every access needed in the current
// pipeline cycle has completed. Program termination parks the block in HALT.
module mem_port_arbiter #(
    parameter int WORD    = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [WORD-1:0]   if_rdata,
    output logic              if_done,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD-1:0]   mem_wdata,
    output logic [WORD-1:0]   mem_rdata,
    output logic              mem_done,
    input  logic              terminate_in,
    output logic              stall,
    output logic              halted,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD-1:0]   ram_wdata,
    input  logic [WORD-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        D_WAIT,
        I_WAIT,
        HALT
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       data_req;

    // A load and a store together are handled as a store.
    assign data_req = mem_r | mem_w;

    // Pipeline may advance only when every requested access has its done flag.
    assign stall = halted | ~((~data_req | mem_done) & (~if_req | if_done));

    // Transaction sequencer: issue, latency countdown, capture and halt.
    // The strobe cycle itself is not counted, so data is taken at the end of
    // the cycle MEM_LAT cycles after ram_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            ram_en <= 1'b0;
            if (!stall) begin
                mem_done <= 1'b0;
                if_done  <= 1'b0;
            end
            if (terminate_in && !stall) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (data_req && !mem_done) begin
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                            ram_we    <= mem_w;
                            ram_en    <= 1'b1;
                            cnt       <= LAT;
                            state     <= D_WAIT;
                        end else if (if_req && !if_done) begin
                            ram_addr <= if_addr;
                            ram_we   <= 1'b0;
                            ram_en   <= 1'b1;
                            cnt      <= LAT;
                            state    <= I_WAIT;
                        end
                    end
                    D_WAIT: begin
                        if (!ram_en) begin
                            if (cnt == 4'd1) begin
                                if (!ram_we) begin
                                    mem_rdata <= ram_rdata;
                                end
                                mem_done <= 1'b1;
                                cnt      <= '0;
                                state    <= IDLE;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                    end
                    I_WAIT: begin
                        if (!ram_en) begin
                            if (cnt == 4'd1) begin
                                if_rdata <= ram_rdata;
                                if_done  <= 1'b1;
                                cnt      <= '0;
                                state    <= IDLE;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter with
// a latency-accurate RAM responder and a pipeline-cycle level reference model.
module tb_mem_port_arbiter;

    localparam int WORD   = 32;
    localparam int ADDR_W = 32;
    localparam int L      = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [WORD-1:0]   if_rdata;
    logic              if_done;
    logic              mem_r = 1'b0;
    logic              mem_w = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [WORD-1:0]   mem_wdata = '0;
    logic [WORD-1:0]   mem_rdata;
    logic              mem_done;
    logic              terminate_in = 1'b0;
    logic              stall;
    logic              halted;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD-1:0]   ram_wdata;
    logic [WORD-1:0]   ram_rdata = '0;

    mem_port_arbiter #(.WORD(WORD), .ADDR_W(ADDR_W), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .terminate_in(terminate_in), .stall(stall), .halted(halted),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Memory seen by the DUT and the reference model's own copy.
    logic [31:0] ram_mem [0:255];
    logic [31:0] ref_mem [0:255];

    typedef struct {
        int       due;
        logic [7:0] idx;
    } rd_t;
    rd_t rd_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;
    acc_t exp_acc[$];

    typedef struct {
        int          stall_cycles;
        logic        if_done;
        logic        mem_done;
        logic [31:0] if_rdata;
        logic [31:0] mem_rdata;
    } res_t;
    res_t exp_res[$];

    bit          mon_en = 1'b0;
    int          stall_cnt = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_mem = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finishRun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Cycle counter used to time RAM responses.
    always @(posedge clk) cyc++;

    // RAM responder: writes land on the strobe, reads return L cycles later,
    // and junk is driven on every other cycle so mistimed captures show up.
    always @(negedge clk) begin
        ram_rdata = $urandom();
        while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            ram_rdata = ram_mem[rd_q[0].idx];
            void'(rd_q.pop_front());
        end
        if (rst && ram_en) begin
            if (ram_we) ram_mem[ram_addr[9:2]] = ram_wdata;
            else rd_q.push_back('{cyc + L, ram_addr[9:2]});
        end
    end

    // Access monitor: every strobe must match the next expected transaction.
    always @(negedge clk) begin
        if (mon_en && rst && ram_en) begin
            if (exp_acc.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL ram_en_unexpected: got strobe at addr %h, expected none (cycle %0d)", ram_addr, cyc);
            end else begin
                acc_t a;
                a = exp_acc.pop_front();
                checkOutput("ram_addr", ram_addr, a.addr);
                checkOutput("ram_we", 32'(ram_we), 32'(a.we));
                if (a.we) checkOutput("ram_wdata", ram_wdata, a.wdata);
            end
        end
    end

    // Result monitor: at each stall release compare duration, flags and data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall) begin
                stall_cnt++;
            end else if (exp_res.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL release_unexpected: got stall=0, expected no release (cycle %0d)", cyc);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                checkOutput("stall_cycles", 32'(stall_cnt), 32'(r.stall_cycles));
                checkOutput("if_done", 32'(if_done), 32'(r.if_done));
                checkOutput("mem_done", 32'(mem_done), 32'(r.mem_done));
                checkOutput("if_rdata", if_rdata, r.if_rdata);
                checkOutput("mem_rdata", mem_rdata, r.mem_rdata);
                stall_cnt = 0;
            end
        end
    end

    // Drive one pipeline cycle's requests and record what must happen.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic mr,
                                 input logic mw, input logic [31:0] ma, input logic [31:0] wd,
                                 input logic term);
        int cycles;
        res_t r;
        cycles = 0;
        if_req = ir; if_addr = ia; mem_r = mr; mem_w = mw;
        mem_addr = ma; mem_wdata = wd; terminate_in = term;
        if (mr || mw) begin
            cycles += L + 2;
            exp_acc.push_back('{ma, mw, wd});
            if (mw) ref_mem[ma[9:2]] = wd;
            else last_mem = ref_mem[ma[9:2]];
        end
        if (ir) begin
            cycles += L + 2;
            exp_acc.push_back('{ia, 1'b0, 32'h0});
            last_if = ref_mem[ia[9:2]];
        end
        r.stall_cycles = cycles;
        r.if_done      = ir;
        r.mem_done     = mr | mw;
        r.if_rdata     = last_if;
        r.mem_rdata    = last_mem;
        exp_res.push_back(r);
    endtask

    // Wait for the release cycle, then step into the next pipeline cycle.
    task automatic waitRelease();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL stall_timeout: got stall=1 after %0d cycles, expected release", n);
            finishRun();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomCycles(input int count);
        for (int i = 0; i < count; i++) begin
            logic [31:0] ia, ma;
            ia = 32'($urandom_range(0, 31)) << 2;
            ma = 32'($urandom_range(0, 31)) << 2;
            applyStimulus(1'($urandom_range(0, 3) != 0), ia, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), ma, $urandom(), 1'b0);
            waitRelease();
        end
    endtask

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        finishRun();
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'h5A000000 ^ (32'(i) * 32'h00010003);
            ref_mem[i] = 32'h5A000000 ^ (32'(i) * 32'h00010003);
        end
        ram_mem[8'h10] = 32'h8C220004; ref_mem[8'h10] = 32'h8C220004;
        ram_mem[8'h40] = 32'h00001234; ref_mem[8'h40] = 32'h00001234;

        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ram_en", 32'(ram_en), 32'h0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
        checkOutput("rst_ram_addr", ram_addr, 32'h0);
        checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
        checkOutput("rst_if_rdata", if_rdata, 32'h0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
        checkOutput("rst_if_done", 32'(if_done), 32'h0);
        checkOutput("rst_mem_done", 32'(mem_done), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed pipeline cycles: fetch only, load+fetch, store, back-to-back fetches.
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        waitRelease();
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        waitRelease();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0);
        waitRelease();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        waitRelease();
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        waitRelease();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h0BADF00D, 1'b0);
        waitRelease();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        waitRelease();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        waitRelease();

        randomCycles(80);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        waitRelease();

        // Reset in the middle of a load: outputs clear at once, stale data ignored.
        mon_en = 1'b0;
        mem_r = 1'b1; mem_addr = 32'h100; if_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_ram_en", 32'(ram_en), 32'h0);
        checkOutput("midrst_ram_addr", ram_addr, 32'h0);
        checkOutput("midrst_ram_we", 32'(ram_we), 32'h0);
        checkOutput("midrst_mem_rdata", mem_rdata, 32'h0);
        checkOutput("midrst_if_rdata", if_rdata, 32'h0);
        checkOutput("midrst_mem_done", 32'(mem_done), 32'h0);
        mem_r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("stale_mem_done", 32'(mem_done), 32'h0);
            checkOutput("stale_mem_rdata", mem_rdata, 32'h0);
            checkOutput("stale_ram_en", 32'(ram_en), 32'h0);
        end
        @(posedge clk);
        #1;
        last_if = '0;
        last_mem = '0;
        stall_cnt = 0;
        exp_acc.delete();
        exp_res.delete();
        mon_en = 1'b1;
        randomCycles(10);

        // Terminate: halted and permanent stall, no further memory traffic.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        waitRelease();
        terminate_in = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; mem_r = 1'b1; mem_addr = 32'h100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halt_halted", 32'(halted), 32'h1);
            checkOutput("halt_stall", 32'(stall), 32'h1);
            checkOutput("halt_ram_en", 32'(ram_en), 32'h0);
        end
        checkOutput("left_accesses", 32'(exp_acc.size()), 32'h0);
        checkOutput("left_results", 32'(exp_res.size()), 32'h0);
        finishRun();
    end

endmodule
